fp_div48_sched: RTL
===================

FP_DIV48_SCHED -- requirements
Module: fp_div48_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one fpDivide48nr instance (2..8).
REQ-002 Parameter TIMEOUT, default 255, maximum cycles from div_ld to div_done before abort.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port req_valid  input  NREQ  per-requester operation request.
REQ-006 Port req_ready  output  NREQ  per-requester grant; the handshake completes when valid and ready are both high.
REQ-007 Port req_a, req_b  input  NREQ x FP48  dividend and divisor per requester.
REQ-008 Port req_rm  input  NREQ x 3  rounding mode per requester.
REQ-009 Port div_ld  output  1  load pulse to the divider.
REQ-010 Port div_a, div_b  output  FP48  divider operands; div_rm  output  3  divider rounding mode.
REQ-011 Port div_done  input  1  divider done, delayed 2 cycles as in fpDivide48nr.
REQ-012 Port div_o  input  FP48  rounded divider result; div_flags  input  4  {sign_exe,inf,overflow,underflow}.
REQ-013 Port rsp_valid  output  1; rsp_ready  input  1  result handshake.
REQ-014 Port rsp_id  output  $clog2(NREQ)  index of the requester that owns the result.
REQ-015 Port rsp_o  output  FP48; rsp_flags  output  4; rsp_timeout  output  1  result aborted by the watchdog.
REQ-016 Port busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, LOAD, WAITLO, WAITHI, RESP.
REQ-018 IDLE: a round-robin arbiter picks the first valid requester after last_grant (wrapping); req_ready is one-hot for the winner in the same cycle and zero elsewhere; on the handshake the block latches the operands, rm and id, and goes to LOAD.
REQ-019 req_ready is all zero in every state other than IDLE.
REQ-020 LOAD: div_ld=1 for exactly one cycle while div_a, div_b and div_rm hold the latched values; next state WAITLO.
REQ-021 div_a, div_b and div_rm hold stable from LOAD until RESP is exited.
REQ-022 WAITLO: the stale high on div_done is ignored; the FSM moves to WAITHI on the first cycle in which div_done=0.
REQ-023 WAITHI: on div_done=1 the block captures div_o and div_flags into the result register, sets rsp_valid, and goes to RESP.
REQ-024 Watchdog: an 8-bit (or $clog2(TIMEOUT+1)-bit) counter clears in LOAD and increments in WAITLO and WAITHI; when it reaches TIMEOUT, the block goes to RESP with rsp_timeout=1, rsp_o=0 and rsp_flags=0.
REQ-025 RESP: rsp_valid=1 and rsp_id, rsp_o, rsp_flags and rsp_timeout are stable until rsp_ready=1; on the handshake the block moves to IDLE, rsp_valid drops in the next cycle, and last_grant is set to rsp_id.
REQ-026 No new request is granted in the cycle of the RESP handshake; the earliest new grant is the following IDLE cycle.
REQ-027 Minimum throughput is one operation per (divider latency + 4) cycles.
REQ-028 Requests arriving while the block is busy wait with valid held; none is dropped.
REQ-029 Fairness: with all NREQ requests continuously valid, grants rotate 0,1,..,NREQ-1,0.
REQ-030 If div_done=1 and the watchdog expires in the same WAITHI cycle, the block captures the result normally with rsp_timeout=0.

Reset
REQ-031 When rst=0, asynchronously: state=IDLE; last_grant=NREQ-1 so requester 0 wins first; all outputs are 0, including req_ready, div_ld, div_a, div_b, div_rm, rsp_valid, rsp_id, rsp_o, rsp_flags, rsp_timeout and busy; the watchdog is 0.
REQ-032 Reset in the middle of an operation discards the operation; no rsp_valid is produced for it after reset is released.
REQ-033 The first grant is possible in the first clock edge after rst is deasserted.

Structure
REQ-034 The FP48 type, the flag-vector width (4), and the state enum fp_div_sched_state_t belong in fp48Pkg.
REQ-035 The round-robin arbiter is one sub-module, fp_rr_arbiter (NREQ, req, last, grant_onehot, grant_idx), and is purely combinational.
REQ-036 fpDivide48nr is instantiated by the parent and not inside this block.

Verification
REQ-037 Single op: requester 2 with a=6.0, b=2.0, rm=0, divider model returns 3.0 -> div_ld is one pulse, rsp_id=2, rsp_o=3.0, rsp_flags=0, rsp_timeout=0.
REQ-038 Contention: all 4 requesters valid from reset -> grant order 0,1,2,3,0 and rsp_id sequence matches.
REQ-039 Backpressure: rsp_ready held low for 20 cycles -> rsp outputs stable, req_ready stays 0, no second div_ld.
REQ-040 Timeout: divider model never raises div_done -> rsp_timeout=1 after TIMEOUT cycles, then the next request is granted normally.
REQ-041 Stale done: div_done held high for 2 cycles after div_ld -> no early capture; the result is taken on the true rising done.
REQ-042 Reset mid-op: rst=0 asserted during WAITHI -> all outputs 0 immediately; no rsp_valid after release until a new request completes.

Source files
------------

// File: rtl/fp_div48_sched_pkg.sv
// Shared types for the fp48 divider scheduler: operand/flag widths, FSM
// state encoding and the latched-operation record.
package fp48Pkg;

  localparam int FP48_W  = 48;
  localparam int FLAGS_W = 4;
  localparam int RM_W    = 3;

  typedef logic [FP48_W-1:0]  fp48_t;
  typedef logic [FLAGS_W-1:0] fp_flags_t;
  typedef logic [RM_W-1:0]    fp_rm_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAITLO,
    WAITHI,
    RESP
  } fp_div_sched_state_t;

  typedef struct packed {
    fp48_t  a;
    fp48_t  b;
    fp_rm_t rm;
  } fp_div_op_t;

endpackage

// File: rtl/fp_div48_sched_arb.sv
// Combinational round-robin arbiter: grants the first requester after
// 'last', wrapping, as both a one-hot vector and an index.
module fp_rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  grant_onehot,
  output logic [IDX_W-1:0] grant_idx
);

  int   cand;
  logic found;

  // NOTE: every output gets a default before the loop, so no path through
  // this block leaves a value held and no latch is inferred.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    cand         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!found && req[cand]) begin
        found              = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_idx          = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fp_div48_sched.sv
// Shares one external fp48 divider between NREQ requesters: round-robin
// grant, one load pulse per operation, watchdog abort, held result handshake.
module fp_div48_sched
  import fp48Pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 255,
  localparam int IDX_W   = $clog2(NREQ),
  localparam int WD_W    = $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  fp48_t [NREQ-1:0]    req_a,
  input  fp48_t [NREQ-1:0]    req_b,
  input  fp_rm_t [NREQ-1:0]   req_rm,
  output logic                div_ld,
  output fp48_t               div_a,
  output fp48_t               div_b,
  output fp_rm_t              div_rm,
  input  logic                div_done,
  input  fp48_t               div_o,
  input  fp_flags_t           div_flags,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDX_W-1:0]    rsp_id,
  output fp48_t               rsp_o,
  output fp_flags_t           rsp_flags,
  output logic                rsp_timeout,
  output logic                busy
);

  fp_div_sched_state_t state, state_n;
  logic [IDX_W-1:0]    last_grant, grant_idx, op_id;
  logic [NREQ-1:0]     grant_onehot;
  fp_div_op_t          op;
  logic [WD_W-1:0]     wd;
  logic                wd_expired, take_req, capture, abort;

  fp_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req          (req_valid),
    .last         (last_grant),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  assign wd_expired = (wd == WD_W'(TIMEOUT));

  always_comb begin
    state_n  = state;
    take_req = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: if (|req_valid) begin
        take_req = 1'b1;
        state_n  = LOAD;
      end
      LOAD: state_n = WAITLO;
      // The divider's done is still high from its previous result here.
      WAITLO: if (wd_expired) begin
        abort   = 1'b1;
        state_n = RESP;
      end else if (!div_done) begin
        state_n = WAITHI;
      end
      // A real done wins over a watchdog expiring in the same cycle.
      WAITHI: if (div_done) begin
        capture = 1'b1;
        state_n = RESP;
      end else if (wd_expired) begin
        abort   = 1'b1;
        state_n = RESP;
      end
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: operand and result registers are reset as well as the state,
  // because they drive outputs that must read zero while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= IDX_W'(NREQ - 1);
      op          <= '0;
      op_id       <= '0;
      wd          <= '0;
      rsp_o       <= '0;
      rsp_flags   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples pre-edge values regardless of statement order.
      state <= state_n;
      if (take_req) begin
        op    <= '{a: req_a[grant_idx], b: req_b[grant_idx], rm: req_rm[grant_idx]};
        op_id <= grant_idx;
      end
      if (state == LOAD) begin
        wd <= '0;
      end else if (state == WAITLO || state == WAITHI) begin
        wd <= wd + 1'b1;
      end
      if (capture) begin
        rsp_o       <= div_o;
        rsp_flags   <= div_flags;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_o       <= '0;
        rsp_flags   <= '0;
        rsp_timeout <= 1'b1;
      end
      if (state == RESP && rsp_ready) last_grant <= op_id;
    end
  end

  // Grants are masked by reset so nothing is offered while rst is low.
  assign req_ready = (state == IDLE && rst) ? grant_onehot : '0;
  assign div_ld    = (state == LOAD);
  assign div_a     = op.a;
  assign div_b     = op.b;
  assign div_rm    = op.rm;
  assign rsp_valid = (state == RESP);
  assign rsp_id    = op_id;
  assign busy      = (state != IDLE);

endmodule
